seg7_display_ctrl: RTL and testbench
====================================

SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 Parameter BLINK_DIV, default 12500000, clock cycles per blink half-period (minimum 2).
REQ-002 Parameter SCROLL_DIV, default 25000000, clock cycles per scroll step (minimum 2).
REQ-003 Port clk, input, 1, single system clock; all logic is rising-edge.
REQ-004 Port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-005 Port wr_valid, input, 1, register write request.
REQ-006 Port wr_ready, output, 1, controller can accept a write this cycle.
REQ-007 Port wr_addr, input, 2, register select: 0 VALUE, 1 CTRL, 2 SCROLL, 3 reserved.
REQ-008 Port wr_data, input, 32, write data.
REQ-009 Ports hex0..hex5, output, 8 each, active-low segments: bits 6:0 are segments g..a, bit 7 is the decimal point.
REQ-010 Port mode, output, 2, current FSM state encoding (OFF=0, STATIC=1, SCROLL=2).

Function
REQ-011 A write SHALL be accepted on a cycle where wr_valid and wr_ready are both high, and the register SHALL update on that edge.
REQ-012 wr_ready SHALL be low for exactly the one cycle following an accepted write and high otherwise, giving at most one write per 2 cycles.
REQ-013 VALUE write: bits 23:0 SHALL be stored as six nibbles; nibble k drives hexk.
REQ-014 CTRL write: bit0 enable, bit1 blink, bit2 scroll, bits 13:8 per-digit blank mask, bits 21:16 per-digit DP mask; other bits are ignored.
REQ-015 SCROLL write: all 32 bits SHALL load an 8-nibble ring, reset the scroll position to 0, and clear the scroll counter.
REQ-016 Reserved address writes SHALL be accepted, with wr_ready behaving per REQ-012, and SHALL have no other effect.
REQ-017 FSM transitions: OFF when enable=0; STATIC when enable=1 and scroll=0; SCROLL when enable=1 and scroll=1. Each transition SHALL be evaluated from the CTRL value registered on the previous edge.
REQ-018 OFF: all hex outputs SHALL be 8'hFF, and the blink and scroll counters SHALL hold at 0.
REQ-019 STATIC: each hexk SHALL be the decode of VALUE nibble k.
REQ-020 SCROLL: hexk SHALL be the decode of ring nibble (k+2) after rotation; ring nibbles 7..2 are shown on hex5..hex0.
REQ-021 In SCROLL, the ring SHALL rotate left by one nibble, with nibble 7 wrapping to nibble 0, when the scroll counter reaches SCROLL_DIV-1. The counter SHALL then return to 0.
REQ-022 After 8 scroll steps, the ring SHALL equal its loaded value (wrap-around).
REQ-023 If a SCROLL write and a scroll tick occur on the same edge, the write SHALL win and no rotation occurs.
REQ-024 The blink counter SHALL run in STATIC and SCROLL and toggle blink_phase every BLINK_DIV cycles. blink_phase SHALL be 0 after reset and after leaving OFF.
REQ-025 When blink=1 and blink_phase=1, all hex outputs SHALL be 8'hFF.
REQ-026 A digit with its blank bit set SHALL output 8'hFF regardless of mode.
REQ-027 For a digit that is not blanked, the DP bit SHALL be the inverse of its DP mask bit.
REQ-028 Hex outputs SHALL be registered: one cycle from a register update or rotation to a visible change.
REQ-029 Decode SHALL cover 0-F using the standard hex glyphs (e.g. 2 -> 7'b0100100 active-low, A -> 7'b0001000).

Reset
REQ-030 While reset is high: VALUE, CTRL, the ring, both counters and blink_phase SHALL be 0; mode SHALL be OFF; hex0..hex5 SHALL be 8'hFF; wr_ready SHALL be 0.
REQ-031 wr_ready SHALL rise on the first cycle after reset deasserts.
REQ-032 Reset asserted mid-scroll or mid-write SHALL discard all state, and no write SHALL be accepted while reset is high.

Structure
REQ-033 The register address constants, CTRL bit positions and mode encodings SHALL live in the shared globals definitions file.
REQ-034 Nibble-to-segment decode SHALL be a combinational sub-module seg7_decode (4-bit in, 7-bit active-low out), instantiated six times.
REQ-035 No other sub-modules are permitted; the FSM, counters and registers SHALL reside in seg7_display_ctrl.

Verification (bench uses BLINK_DIV=4, SCROLL_DIV=3)
REQ-036 Reset held for 3 cycles -> all hex = 8'hFF, wr_ready=0, mode=0. Release -> wr_ready=1 on the next cycle.
REQ-037 Write VALUE=0x424242, then CTRL=0x1 -> mode=1, hex0=hex2=hex4 show "2" (0xA4) and hex1=hex3=hex5 show "4" (0x99). wr_ready is low for one cycle after each write.
REQ-038 Write CTRL=0x3 (blink) -> all hex alternate between glyphs and 0xFF every 4 cycles.
REQ-039 Write SCROLL=0x01234567, then CTRL=0x5 -> display reads 012345, then 123456 after 3 cycles, and returns to 012345 after 24 cycles.
REQ-040 Write CTRL=0x00010F01 -> hex0..hex3 = 0xFF; hex4 shows its digit with bit7=0 only if DP mask bit 4 is set (here bit 16 selects hex0, which is blanked, so it remains 0xFF).
REQ-041 Assert reset during SCROLL with a simultaneous wr_valid -> no write is accepted, and all outputs match REQ-030 on the next edge.

Source files
------------

// File: rtl/seg7_display_ctrl_pkg.sv
// Shared register map, CTRL field layout and display-mode encodings for the
// six-digit seven-segment controller.
package seg7_display_ctrl_pkg;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_SCROLL = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_BLINK_BIT  = 1;
    localparam int unsigned CTRL_SCROLL_BIT = 2;
    localparam int unsigned CTRL_BLANK_LSB  = 8;
    localparam int unsigned CTRL_DP_LSB     = 16;

    localparam int unsigned NUM_DIGITS = 6;
    localparam logic [7:0]  HEX_DARK   = 8'hFF;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_STATIC = 2'd1;
    localparam logic [1:0] MODE_SCROLL = 2'd2;

    typedef struct packed {
        logic [5:0] dp;
        logic [5:0] blank;
        logic       scroll;
        logic       blink;
        logic       en;
    } ctrl_t;

    function automatic logic [1:0] next_mode(input ctrl_t c);
        if (!c.en)
            return MODE_OFF;
        else if (c.scroll)
            return MODE_SCROLL;
        else
            return MODE_STATIC;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment glyph (bits 6:0 = g..a).
module seg7_decode (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        unique case (nibble_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            default: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Six-digit seven-segment display controller: register-mapped value/ctrl/scroll
// ring, OFF/STATIC/SCROLL mode FSM, blink and scroll dividers, registered outputs.
module seg7_display_ctrl
    import seg7_display_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_DIV  = 12500000,
    parameter int unsigned SCROLL_DIV = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3,
    output logic [7:0]  hex4,
    output logic [7:0]  hex5,
    output logic [1:0]  mode
);

    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam int unsigned SW = $clog2(SCROLL_DIV);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_DIV - 1);

    logic [23:0]   value_q, value_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [31:0]   ring_q, ring_d;
    logic [1:0]    mode_q, mode_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [SW-1:0] scroll_cnt_q, scroll_cnt_d;
    logic          wr_ready_q, wr_ready_d;
    logic [7:0]    hex_q [NUM_DIGITS];
    logic [7:0]    hex_d [NUM_DIGITS];
    logic [6:0]    seg_w [NUM_DIGITS];
    logic          wr_fire;

    // SCROLL mode shows ring nibbles 7..2 on hex5..hex0; otherwise VALUE nibble k.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
        logic [3:0] nib;
        assign nib = (mode_q == MODE_SCROLL) ? ring_q[4*(k+2) +: 4] : value_q[4*k +: 4];
        seg7_decode u_dec (
            .nibble_i (nib),
            .seg_o    (seg_w[k])
        );
    end

    always_comb begin
        wr_fire       = wr_valid && wr_ready_q;
        value_d       = value_q;
        ctrl_d        = ctrl_q;
        ring_d        = ring_q;
        mode_d        = next_mode(ctrl_q);
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        scroll_cnt_d  = '0;

        if (mode_q != MODE_OFF) begin
            blink_phase_d = blink_phase_q;
            if (blink_cnt_q == BLINK_LAST)
                blink_phase_d = ~blink_phase_q;
            else
                blink_cnt_d = blink_cnt_q + BW'(1);
        end

        if (mode_q == MODE_SCROLL) begin
            if (scroll_cnt_q == SCROLL_LAST)
                ring_d = {ring_q[27:0], ring_q[31:28]};
            else
                scroll_cnt_d = scroll_cnt_q + SW'(1);
        end

        // A SCROLL write overrides a rotation landing on the same edge.
        if (wr_fire) begin
            case (wr_addr)
                ADDR_VALUE: value_d = wr_data[23:0];
                ADDR_CTRL: begin
                    ctrl_d.en     = wr_data[CTRL_EN_BIT];
                    ctrl_d.blink  = wr_data[CTRL_BLINK_BIT];
                    ctrl_d.scroll = wr_data[CTRL_SCROLL_BIT];
                    ctrl_d.blank  = wr_data[CTRL_BLANK_LSB +: 6];
                    ctrl_d.dp     = wr_data[CTRL_DP_LSB +: 6];
                end
                ADDR_SCROLL: begin
                    ring_d       = wr_data;
                    scroll_cnt_d = '0;
                end
                default: ;
            endcase
        end
        wr_ready_d = !wr_fire;

        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (ctrl_q.blank[k] || mode_q == MODE_OFF || (ctrl_q.blink && blink_phase_q))
                hex_d[k] = HEX_DARK;
            else
                hex_d[k] = {~ctrl_q.dp[k], seg_w[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q       <= '0;
            ctrl_q        <= '0;
            ring_q        <= '0;
            mode_q        <= MODE_OFF;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            scroll_cnt_q  <= '0;
            wr_ready_q    <= 1'b0;
            hex_q         <= '{default: HEX_DARK};
        end else begin
            value_q       <= value_d;
            ctrl_q        <= ctrl_d;
            ring_q        <= ring_d;
            mode_q        <= mode_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            scroll_cnt_q  <= scroll_cnt_d;
            wr_ready_q    <= wr_ready_d;
            hex_q         <= hex_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign mode     = mode_q;
    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign hex4     = hex_q[4];
    assign hex5     = hex_q[5];

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench: a behavioural model predicts every post-edge output and a
// negedge monitor compares the DUT against the queued predictions.
module tb_seg7_display_ctrl;

    localparam int unsigned BLINK_DIV  = 4;
    localparam int unsigned SCROLL_DIV = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [1:0]  mode;

    seg7_display_ctrl #(
        .BLINK_DIV  (BLINK_DIV),
        .SCROLL_DIV (SCROLL_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] hex;
        logic [1:0]  mode;
        logic        ready;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Active-low glyphs with the decimal point off.
    logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model state: what the display "means", not how the RTL stores it.
    logic [23:0] m_value;
    logic        m_en, m_blink, m_scroll;
    logic [5:0]  m_blank, m_dp;
    logic [31:0] m_ring;
    int          m_pos, m_sc, m_act, m_mode;
    logic        m_phase, m_ready;

    task automatic model_step();
        logic [47:0] h;
        logic [7:0]  g;
        logic [3:0]  nib;
        int          nm, idx;
        logic        accept;
        if (reset) begin
            m_value = '0; m_en = 0; m_blink = 0; m_scroll = 0; m_blank = '0; m_dp = '0;
            m_ring = '0; m_pos = 0; m_sc = 0; m_act = 0; m_mode = 0; m_phase = 0; m_ready = 0;
            h = '1;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (m_blank[k] || m_mode == 0 || (m_blink && m_phase)) begin
                    h[8*k +: 8] = 8'hFF;
                end else begin
                    if (m_mode == 2) begin
                        idx = (k + 2 - m_pos + 8) % 8;
                        nib = m_ring[4*idx +: 4];
                    end else begin
                        nib = m_value[4*k +: 4];
                    end
                    g = GLYPH[nib];
                    g[7] = !m_dp[k];
                    h[8*k +: 8] = g;
                end
            end
            nm = !m_en ? 0 : (m_scroll ? 2 : 1);
            if (m_mode == 0) begin
                m_act = 0; m_phase = 0;
            end else begin
                m_act++;
                m_phase = ((m_act / BLINK_DIV) % 2) == 1;
            end
            if (m_mode == 2) begin
                m_sc++;
                if (m_sc == SCROLL_DIV) begin m_sc = 0; m_pos = (m_pos + 1) % 8; end
            end else begin
                m_sc = 0;
            end
            accept = wr_valid && m_ready;
            if (accept) begin
                case (wr_addr)
                    2'd0: m_value = wr_data[23:0];
                    2'd1: begin
                        m_en = wr_data[0]; m_blink = wr_data[1]; m_scroll = wr_data[2];
                        m_blank = wr_data[13:8]; m_dp = wr_data[21:16];
                    end
                    2'd2: begin m_ring = wr_data; m_pos = 0; m_sc = 0; end
                    default: ;
                endcase
            end
            m_ready = !accept;
            m_mode  = nm;
        end
        sb_q.push_back('{hex: h, mode: 2'(m_mode), ready: m_ready});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("wr_ready", 32'(wr_ready), 32'(e.ready));
            chk("mode", 32'(mode), 32'(e.mode));
            chk("hex0", 32'(hex0), 32'(e.hex[7:0]));
            chk("hex1", 32'(hex1), 32'(e.hex[15:8]));
            chk("hex2", 32'(hex2), 32'(e.hex[23:16]));
            chk("hex3", 32'(hex3), 32'(e.hex[31:24]));
            chk("hex4", 32'(hex4), 32'(e.hex[39:32]));
            chk("hex5", 32'(hex5), 32'(e.hex[47:40]));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_step();
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        tick(3);
        reset = 1'b0;
        tick(2);

        do_write(2'd0, 32'h0042_4242);
        do_write(2'd1, 32'h0000_0001);
        tick(4);
        do_write(2'd1, 32'h0000_0003);
        tick(20);
        do_write(2'd2, 32'h0123_4567);
        do_write(2'd1, 32'h0000_0005);
        tick(30);
        do_write(2'd1, 32'h0001_0F01);
        tick(4);
        do_write(2'd1, 32'h0010_0F01);
        tick(4);
        do_write(2'd3, 32'hFFFF_FFFF);
        tick(3);

        // Reset landing mid-scroll with a pending write.
        do_write(2'd1, 32'h0000_0005);
        tick(7);
        reset = 1'b1; wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 32'h00AB_CDEF;
        tick(2);
        reset = 1'b0; wr_valid = 1'b0;
        tick(3);

        for (int i = 0; i < 1500; i++) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = 2'($urandom_range(0, 3));
            wr_data  = $urandom;
            if (wr_addr == 2'd1 && $urandom_range(0, 1) == 1) wr_data[13:8] = '0;
            if (wr_addr == 2'd1 && $urandom_range(0, 3) != 0) wr_data[0] = 1'b1;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; wr_valid = 1'b0;
        tick(2);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
